uc_ctrl: RTL and testbench
==========================

Name: uc_ctrl

Overview:
- Control unit for the microc single-cycle datapath, directly upstream of it.
- Consumes the datapath's Opcode and zero outputs each cycle.
- Produces s_inc, s_inm, we, wez and ALUOp for the same cycle.
- Adds a RUN/HALT state machine, a sticky illegal-opcode flag and optional performance counters. These replace the hand-driven control sequences used in bring-up.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  6  opcode field of the current instruction, from microc.
- zero  in  1  registered zero flag, from microc.
- resume  in  1  leave HALT; sampled only in HALT.
- s_inc  out  1  1 = PC+1, 0 = jump target.
- s_inm  out  1  1 = immediate operand, 0 = register operand.
- we  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- ALUOp  out  3  ALU operation.
- halted  out  1  1 while in HALT.
- illegal  out  1  sticky; set on any undefined opcode.
- instr_cnt  out  CNT_W  retired-instruction count (PERF_CNT_EN only).
- br_cnt  out  CNT_W  taken-branch count (PERF_CNT_EN only).

Behaviour:
- Control outputs are combinational from Opcode, zero and state, with zero-cycle latency. State, flags and counters are registered.
- Opcode decode in RUN state, giving s_inc s_inm we wez ALUOp:
  - 00ppp0 ALU reg-reg: 1 0 1 1 ppp.
  - 00ppp1 ALU immediate (ADI/SBI): 1 1 1 1 ppp.
  - 010000 LI: 1 1 1 0 000.
  - 010001 J: 0 0 0 0 000.
  - 010010 JZ: ~zero 0 0 0 000 (jump when zero=1).
  - 010011 JNZ: zero 0 0 0 000 (jump when zero=0).
  - 111111 HALT: 0 0 0 0 000. The assembler encodes the HALT's own address as the target, so the PC self-loops.
  - Any other opcode is a NOP: 1 0 0 0 000, and illegal is set next edge.
- FSM states are RUN and HALT.
- RUN -> HALT on a clock edge when Opcode==111111.
- HALT -> RUN on a clock edge when resume==1.
- In HALT without resume, outputs are s_inc=0, we=0, wez=0, s_inm=0, ALUOp=000 regardless of Opcode.
- In HALT with resume=1, outputs are s_inc=1 with all writes 0 for that cycle, so the PC steps past the HALT on the same edge the state returns to RUN.
- resume is ignored in RUN.
- halted = (state==HALT), registered.
- While reset=1:
  - outputs are forced to s_inc=1, s_inm=0, we=0, wez=0, ALUOp=000;
  - on the edge, state becomes RUN and halted, illegal and both counters clear to 0.
- A reset during HALT returns to RUN on the same edge. Reset takes priority over resume and over HALT detection.
- The illegal flag clears only on reset. Detection of a further illegal opcode while it is already set has no further effect.

Optional Feature:
- Macro: PERF_CNT_EN.
- With PERF_CNT_EN defined:
  - instr_cnt increments by 1 on each edge in RUN where the opcode is legal and not HALT.
  - br_cnt increments by 1 on each edge in RUN with J, taken JZ or taken JNZ.
  - Both counters saturate at 2^CNT_W-1 (no wrap) and clear on reset.
  - Neither counter changes in HALT, including the resume cycle.
- Without PERF_CNT_EN: no counter registers are generated, and instr_cnt and br_cnt are tied to 0.

Test Plan:
1. Reset sequence: hold reset 1 cycle with Opcode=000101 -> outputs 1/0/0/0/000 during reset; halted=0, illegal=0, counters=0 after.
2. ALU decode: Opcode=000110 (SUB reg) -> s_inc=1, s_inm=0, we=1, wez=1, ALUOp=011. Opcode=000111 (SBI) -> s_inm=1, ALUOp=011. Opcode=010000 (LI) -> we=1, wez=0, s_inm=1.
3. Branches:
   - JZ with zero=1 -> s_inc=0; JZ with zero=0 -> s_inc=1.
   - JNZ with zero=0 -> s_inc=0.
   - J -> s_inc=0 regardless of zero.
   - With PERF_CNT_EN, after J, taken JZ and untaken JZ: br_cnt=2, instr_cnt=3.
4. Halt/resume:
   - Opcode=111111 -> s_inc=0 immediately; halted=1 after the edge.
   - Change Opcode to 001000 while halted -> outputs stay 0/0/0/0/000.
   - resume=1 for one cycle -> s_inc=1 that cycle; halted=0 next edge.
5. Illegal opcode and reset during HALT:
   - Opcode=011111 -> NOP outputs; illegal=1 after the edge and stays 1 through later legal opcodes.
   - Reset while halted -> halted=0 and illegal=0 after the edge.
6. Saturation (CNT_W=4, PERF_CNT_EN): 20 consecutive reg-reg ALU cycles -> instr_cnt stops at 15 and does not wrap to 0.

Source files
------------

// File: rtl/uc_ctrl_if.sv
// Bus between the microc datapath and its control unit.
// The controller takes the slave side; the datapath or a bench takes master.
interface uc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Opcode;
  logic             zero;
  logic             resume;
  logic             s_inc;
  logic             s_inm;
  logic             we;
  logic             wez;
  logic [2:0]       ALUOp;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] br_cnt;

  modport master (
    output Opcode, zero, resume,
    input  s_inc, s_inm, we, wez, ALUOp,
    input  halted, illegal, instr_cnt, br_cnt
  );

  modport slave (
    input  Opcode, zero, resume,
    output s_inc, s_inm, we, wez, ALUOp,
    output halted, illegal, instr_cnt, br_cnt
  );
endinterface

// File: rtl/uc_ctrl.sv
// microc control unit: opcode decode, RUN/HALT FSM, sticky illegal flag.
// Define PERF_CNT_EN to build the saturating instr/branch counters.
module uc_ctrl #(
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     reset,
  uc_ctrl_if.slave bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_alu;
  logic       w_li;
  logic       w_j;
  logic       w_jz;
  logic       w_jnz;
  logic       w_halt;
  logic       w_legal;
  logic       w_taken;
  logic       w_s_inc;
  logic       w_s_inm;
  logic       w_we;
  logic       w_wez;
  logic [2:0] w_aluop;

  assign w_alu  = (bus.Opcode[5:4] == 2'b00);
  assign w_li   = (bus.Opcode == 6'b010000);
  assign w_j    = (bus.Opcode == 6'b010001);
  assign w_jz   = (bus.Opcode == 6'b010010);
  assign w_jnz  = (bus.Opcode == 6'b010011);
  assign w_halt = (bus.Opcode == 6'b111111);

  assign w_legal = w_alu | w_li | w_j | w_jz | w_jnz | w_halt;
  assign w_taken = w_j | (w_jz & bus.zero) | (w_jnz & ~bus.zero);

  always_comb begin
    w_s_inc = 1'b1;
    w_s_inm = 1'b0;
    w_we    = 1'b0;
    w_wez   = 1'b0;
    w_aluop = 3'b000;
    if (reset) begin
      w_s_inc = 1'b1;
    end else if (r_state == HALT) begin
      // resume steps the PC off the self-looping HALT
      w_s_inc = bus.resume;
    end else begin
      unique case (1'b1)
        w_alu: begin
          w_s_inm = bus.Opcode[0];
          w_we    = 1'b1;
          w_wez   = 1'b1;
          w_aluop = bus.Opcode[3:1];
        end
        w_li: begin
          w_s_inm = 1'b1;
          w_we    = 1'b1;
        end
        w_j:    w_s_inc = 1'b0;
        w_jz:   w_s_inc = ~bus.zero;
        w_jnz:  w_s_inc = bus.zero;
        w_halt: w_s_inc = 1'b0;
        default: w_s_inc = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:  if (w_halt)     w_next = HALT;
      HALT: if (bus.resume) w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_illegal <= 1'b0;
    else if (r_state == RUN && !w_legal)
      r_illegal <= 1'b1;
  end

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_instr;
  logic [CNT_W-1:0] r_br;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_br    <= '0;
    end else if (r_state == RUN) begin
      if (w_legal && !w_halt && r_instr != '1)
        r_instr <= r_instr + ONE;
      if (w_taken && r_br != '1)
        r_br <= r_br + ONE;
    end
  end

  assign bus.instr_cnt = r_instr;
  assign bus.br_cnt    = r_br;
`else
  logic [CNT_W-1:0] w_cnt_zero;
  logic             w_unused;

  assign w_cnt_zero    = '0;
  assign w_unused      = w_taken;
  assign bus.instr_cnt = w_cnt_zero;
  assign bus.br_cnt    = w_cnt_zero;
`endif

  assign bus.s_inc   = w_s_inc;
  assign bus.s_inm   = w_s_inm;
  assign bus.we      = w_we;
  assign bus.wez     = w_wez;
  assign bus.ALUOp   = w_aluop;
  assign bus.halted  = (r_state == HALT);
  assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_uc_ctrl.sv
// Scoreboard bench for uc_ctrl: directed vectors queue expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_uc_ctrl;

  localparam int CW = 4;

  logic clk;
  logic reset;

  uc_ctrl_if #(.CNT_W(CW)) u_if ();

  uc_ctrl #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_CTRL  = 0;
  localparam int K_HALT  = 1;
  localparam int K_ILL   = 2;
  localparam int K_INSTR = 3;
  localparam int K_BR    = 4;

  typedef struct {
    string       nm;
    int          kind;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int pc(int n);
`ifdef PERF_CNT_EN
    return (n > 15) ? 15 : n;
`else
    return 0 * n;
`endif
  endfunction

  function automatic logic [15:0] actual(int kind);
    logic [15:0] a;
    a = '0;
    case (kind)
      K_CTRL:  a = {9'd0, u_if.s_inc, u_if.s_inm,
                    u_if.we, u_if.wez, u_if.ALUOp};
      K_HALT:  a = {15'd0, u_if.halted};
      K_ILL:   a = {15'd0, u_if.illegal};
      K_INSTR: a = {12'd0, u_if.instr_cnt};
      default: a = {12'd0, u_if.br_cnt};
    endcase
    return a;
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [15:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      n_cmp++;
      if (a !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h", e.nm, a, e.v);
      end
    end
  end

  task automatic exp(string nm, int kind, int v);
    exp_t e;
    e.nm = nm;
    e.kind = kind;
    e.v = 16'(v);
    q.push_back(e);
  endtask

  // one cycle: drive inputs just after the edge, queue the expectations
  task automatic cyc(string nm, logic rst, logic [5:0] op, logic z,
                     logic res, logic [6:0] ctrl);
    @(posedge clk);
    #1;
    reset = rst;
    u_if.Opcode = op;
    u_if.zero = z;
    u_if.resume = res;
    exp(nm, K_CTRL, int'(ctrl));
  endtask

  task automatic st(string nm, int h, int il, int ic, int bc);
    exp({nm, ".halted"}, K_HALT, h);
    exp({nm, ".illegal"}, K_ILL, il);
    exp({nm, ".instr"}, K_INSTR, pc(ic));
    exp({nm, ".br"}, K_BR, pc(bc));
  endtask

  initial begin
    reset = 1'b1;
    u_if.Opcode = 6'b000101;
    u_if.zero = 1'b0;
    u_if.resume = 1'b0;

    cyc("rst",      1, 6'b000101, 0, 0, 7'b1000000);
    cyc("sub",      0, 6'b000110, 0, 0, 7'b1011011);
    st ("sub", 0, 0, 0, 0);
    cyc("sbi",      0, 6'b000111, 0, 0, 7'b1111011);
    st ("sbi", 0, 0, 1, 0);
    cyc("li",       0, 6'b010000, 0, 0, 7'b1110000);
    cyc("jz_t",     0, 6'b010010, 1, 0, 7'b0000000);
    st ("jz_t", 0, 0, 3, 0);
    cyc("jz_n",     0, 6'b010010, 0, 0, 7'b1000000);
    cyc("jnz_t",    0, 6'b010011, 0, 0, 7'b0000000);
    cyc("j_z1",     0, 6'b010001, 1, 0, 7'b0000000);
    cyc("j_z0",     0, 6'b010001, 0, 0, 7'b0000000);
    cyc("halt",     0, 6'b111111, 0, 0, 7'b0000000);
    st ("halt", 0, 0, 8, 4);
    cyc("hold",     0, 6'b001000, 0, 0, 7'b0000000);
    st ("hold", 1, 0, 8, 4);
    cyc("resume",   0, 6'b001000, 0, 1, 7'b1000000);
    st ("resume", 1, 0, 8, 4);
    cyc("ill",      0, 6'b011111, 0, 0, 7'b1000000);
    st ("ill", 0, 0, 8, 4);
    cyc("after_il", 0, 6'b000000, 0, 0, 7'b1011000);
    st ("after_il", 0, 1, 8, 4);
    cyc("halt2",    0, 6'b111111, 1, 0, 7'b0000000);
    st ("halt2", 0, 1, 9, 4);
    cyc("hold2",    0, 6'b000000, 0, 0, 7'b0000000);
    st ("hold2", 1, 1, 9, 4);
    cyc("rst_hlt",  1, 6'b000000, 0, 1, 7'b1000000);
    st ("rst_hlt", 1, 1, 9, 4);
    cyc("j",        0, 6'b010001, 0, 0, 7'b0000000);
    st ("j", 0, 0, 0, 0);
    cyc("jz_t2",    0, 6'b010010, 1, 0, 7'b0000000);
    cyc("jz_n2",    0, 6'b010010, 0, 0, 7'b1000000);
    cyc("alu_res",  0, 6'b000010, 0, 1, 7'b1011001);
    st ("alu_res", 0, 0, 3, 2);
    for (int k = 1; k < 20; k++) begin
      cyc("sat", 0, 6'b001010, 0, 0, 7'b1011101);
      exp("sat.instr", K_INSTR, pc(3 + k));
      exp("sat.halted", K_HALT, 0);
    end
    cyc("sat_end",  0, 6'b000000, 0, 0, 7'b1011000);
    st ("sat_end", 0, 0, 23, 2);

    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
